// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshakes and multi-cycle shift-add multiply
//
// Purpose:
//   Execution unit between decode and writeback. Single-cycle ops (ADD, SUB,
//   AND, OR, XOR, SHL, SHR) are registered on the accept edge. MUL runs an
//   unsigned shift-add loop over WIDTH cycles and then publishes the low WIDTH
//   bits of the product.
//
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - asynchronous active-high reset
//   valid_i  - operands/opcode presented
//   ready_o  - block can accept operands this cycle
//   a_i      - operand A
//   b_i      - operand B (low SHW bits are the shift amount for SHL/SHR)
//   op_i     - opcode: ADD, SUB, AND, OR, XOR, SHL, SHR, MUL (000..111)
//   valid_o  - result register holds a valid result
//   ready_i  - downstream accepts the result
//   alu_o    - result
//   flags_o  - {N, Z, C, V}

module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] alu_o,
    output logic [3:0]       flags_o
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   alu_q, alu_d;
    logic [3:0]         flags_q, flags_d;

    logic               accept;
    logic               is_mul;
    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     sum_w, dif_w, shl_w, shr_w;
    logic [WIDTH-1:0]   res;
    logic               res_c, res_v;
    logic               mul_hi_nz;

    // A new op may enter while the previous result drains in the same cycle.
    assign ready_o = (state_q == S_IDLE) && (!valid_q || ready_i);
    assign accept  = valid_i && ready_o;
    assign is_mul  = (op_i == OP_MUL);
    assign sh      = b_i[SHW-1:0];

    assign valid_o = valid_q;
    assign alu_o   = alu_q;
    assign flags_o = flags_q;

    assign mul_hi_nz = |acc_q[2*WIDTH-1:WIDTH];

    // Single-cycle datapath. The shifts run one bit wider so the last bit
    // shifted out lands in a fixed position: bit WIDTH for SHL, bit 0 for SHR.
    // With sh==0 that extra bit is the zero padding, giving C=0.
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        sum_w = {1'b0, a_i} + {1'b0, b_i};
        dif_w = {1'b0, a_i} - {1'b0, b_i};
        shl_w = {1'b0, a_i} << sh;
        shr_w = {a_i, 1'b0} >> sh;
        case (op_i)
            OP_ADD: begin
                res   = sum_w[WIDTH-1:0];
                res_c = sum_w[WIDTH];
                res_v = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                res   = dif_w[WIDTH-1:0];
                res_c = dif_w[WIDTH];
                res_v = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND: res = a_i & b_i;
            OP_OR:  res = a_i | b_i;
            OP_XOR: res = a_i ^ b_i;
            OP_SHL: begin
                res   = shl_w[WIDTH-1:0];
                res_c = shl_w[WIDTH];
            end
            OP_SHR: begin
                res   = shr_w[WIDTH:1];
                res_c = shr_w[0];
            end
            default: res = '0;
        endcase
    end

    // State register and all datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            alu_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            alu_q   <= alu_d;
            flags_q <= flags_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && is_mul) state_d = S_MUL;
            S_MUL:  if (cnt_q == SHW'(WIDTH - 1)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output register updates.
    always_comb begin
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        valid_d = valid_q;
        alu_d   = alu_q;
        flags_d = flags_q;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept && is_mul) begin
                    a_d   = a_i;
                    b_d   = b_i;
                    acc_d = '0;
                    cnt_d = '0;
                end else if (accept) begin
                    valid_d = 1'b1;
                    alu_d   = res;
                    flags_d = {res[WIDTH-1], (res == '0), res_c, res_v};
                end
            end
            S_MUL: begin
                if (b_q[cnt_q]) begin
                    acc_d = acc_q + ({{WIDTH{1'b0}}, a_q} << cnt_q);
                end
                // Counter wraps back to zero after the last iteration.
                cnt_d = cnt_q + SHW'(1);
            end
            S_DONE: begin
                // Output register is empty here: ready_o stayed low since accept.
                valid_d = 1'b1;
                alu_d   = acc_q[WIDTH-1:0];
                flags_d = {acc_q[WIDTH-1], (acc_q[WIDTH-1:0] == '0), mul_hi_nz, mul_hi_nz};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe

module tb_alu_pipe;

    logic       clk;
    logic       rst;
    logic       valid_in;
    logic       ready_o;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [2:0] op_in;
    logic       valid_o;
    logic       ready_in;
    logic [7:0] alu_o;
    logic [3:0] flags_o;

    int asserts = 0;
    int fails   = 0;

    alu_pipe #(.WIDTH(8)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid_in),
        .ready_o (ready_o),
        .a_i     (a_in),
        .b_i     (b_in),
        .op_i    (op_in),
        .valid_o (valid_o),
        .ready_i (ready_in),
        .alu_o   (alu_o),
        .flags_o (flags_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic, result {alu[7:0], N, Z, C, V}.
    function automatic logic [11:0] ref_op(input int op, input int a, input int b);
        int r, c, v, sa, sb, s, sh;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sh = b % 8;
        c  = 0;
        v  = 0;
        case (op)
            0: begin r = a + b; c = (r > 255); s = sa + sb; v = (s > 127 || s < -128); end
            1: begin r = a - b; c = (a < b);   s = sa - sb; v = (s > 127 || s < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = a << sh; c = (sh != 0) && (((r >> 8) & 1) == 1); end
            6: begin r = a >> sh; c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
            default: begin r = a * b; c = (r > 255); v = c; end
        endcase
        r = r & 255;
        return {r[7:0], (r >= 128), (r == 0), c[0], v[0]};
    endfunction

    // Issue one op with ready_in=1, check latency and result, then drain it.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_r, input logic [3:0] exp_f);
        valid_in = 1'b1;
        op_in    = op;
        a_in     = a;
        b_in     = b;
        ready_in = 1'b1;
        #1;
        chk({tag, "_rdy"}, 32'(ready_o), 32'd1);
        tick();
        valid_in = 1'b0;
        if (op == 3'b111) begin
            for (int i = 0; i < 9; i++) begin
                chk({tag, "_busy"}, 32'({ready_o, valid_o}), 32'd0);
                tick();
            end
        end
        chk({tag, "_res"}, 32'({valid_o, alu_o, flags_o}), 32'({1'b1, exp_r, exp_f}));
        tick();
    endtask

    initial begin
        logic [11:0] q[$];
        int acc_n;
        int cyc;

        rst      = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        a_in     = '0;
        b_in     = '0;
        op_in    = '0;
        #2;
        chk("reset_out", 32'({valid_o, alu_o, flags_o}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("reset_rdy", 32'(ready_o), 32'd1);

        run_op("add_ovf",  3'b000, 8'h7F, 8'h01, 8'h80, 4'b1001);
        run_op("add_wrap", 3'b000, 8'hFF, 8'h01, 8'h00, 4'b0110);
        run_op("sub_brw",  3'b001, 8'h00, 8'h01, 8'hFF, 4'b1010);
        run_op("sub_zero", 3'b001, 8'h55, 8'h55, 8'h00, 4'b0100);
        run_op("shl_1",    3'b101, 8'h81, 8'h01, 8'h02, 4'b0010);
        run_op("shr_hi",   3'b110, 8'h81, 8'h09, 8'h40, 4'b0010);
        run_op("shl_0",    3'b101, 8'hA5, 8'h00, 8'hA5, 4'b1000);
        run_op("shl_hi",   3'b101, 8'hE1, 8'h0B, 8'h08, 4'b0010);
        run_op("and",      3'b010, 8'hF0, 8'h3C, 8'h30, 4'b0000);
        run_op("mul_hi",   3'b111, 8'h10, 8'h11, 8'h10, 4'b0011);
        run_op("mul_lo",   3'b111, 8'h0F, 8'h0F, 8'hE1, 4'b1000);
        run_op("mul_zero", 3'b111, 8'h00, 8'h37, 8'h00, 4'b0100);

        // Backpressure: ADD 3+4 held, then new XOR accepted as it drains.
        valid_in = 1'b1; op_in = 3'b000; a_in = 8'h03; b_in = 8'h04; ready_in = 1'b0;
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold", 32'({valid_o, ready_o, alu_o, flags_o}), 32'({1'b1, 1'b0, 8'h07, 4'b0000}));
            tick();
        end
        valid_in = 1'b1; op_in = 3'b100; a_in = 8'hF0; b_in = 8'hFF; ready_in = 1'b1;
        #1;
        chk("bp_accept", 32'(ready_o), 32'd1);
        tick();
        valid_in = 1'b0;
        chk("bp_xor", 32'({valid_o, alu_o, flags_o}), 32'({1'b1, 8'h0F, 4'b0000}));
        tick();

        // Reset in the middle of a multiply.
        valid_in = 1'b1; op_in = 3'b111; a_in = 8'h10; b_in = 8'h11;
        tick();
        valid_in = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("rst_mid", 32'({valid_o, alu_o, flags_o}), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_rdy", 32'(ready_o), 32'd1);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("rst_stale", 32'(valid_o), 32'd0);
        end

        // Random back-to-back traffic against the reference model.
        acc_n = 0;
        cyc   = 0;
        while ((acc_n < 1000 || q.size() != 0) && cyc < 40000) begin
            valid_in = ($urandom_range(0, 3) != 0) && (acc_n < 1000);
            op_in    = 3'($urandom_range(0, 7));
            a_in     = 8'($urandom);
            b_in     = 8'($urandom);
            ready_in = ($urandom_range(0, 3) != 0);
            #1;
            if (valid_o && ready_in) begin
                if (q.size() == 0) chk("rnd_spurious", 32'(valid_o), 32'd0);
                else chk("rnd", 32'({alu_o, flags_o}), 32'(q.pop_front()));
            end
            if (valid_in && ready_o) begin
                q.push_back(ref_op(int'(op_in), int'(a_in), int'(b_in)));
                acc_n++;
            end
            tick();
            cyc++;
        end
        chk("rnd_count", 32'(acc_n), 32'd1000);
        chk("rnd_drain", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
